sram_req_ctrl: RTL and testbench

Initiator-side controller for the 32x128 single-port SRAM macro port (clk0/csb0/web0/addr0/din0/dout0). It converts a valid/ready request channel into macro accesses and returns read data on a valid/ready response channel. A response FIFO absorbs read data under backpressure, so no read data is ever lost. It sits between bus/core logic and the SRAM wrapper, driving that wrapper's io_* pins directly.

---
 rtl/sram_req_ctrl.sv | 105 ++++++++++
 tb/tb_sram_req_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - valid/ready request front end for a 32x128 single-port SRAM macro
//
// Purpose:
//   Turns a valid/ready request channel into single-port SRAM macro accesses.
//   Read data returns in request order on a valid/ready response channel.
//   A small response FIFO buffers read data while the consumer applies backpressure.
//   Every read reserves its FIFO slot when it is accepted, so read data is never dropped.
//
// Ports:
//   clock, reset            clock; asynchronous active-low reset
//   io_req_*                request channel (valid/ready, write, addr, wdata)
//   io_resp_*               response channel (valid/ready, rdata)
//   io_sram_*               macro pins (clk0, csb0, web0, addr0, din0 driven; dout0 sampled)

module sram_req_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_write,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [DATA_W-1:0] io_req_wdata,

  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [DATA_W-1:0] io_resp_rdata,

  output logic              io_sram_clk0,
  output logic              io_sram_csb0,
  output logic              io_sram_web0,
  output logic [ADDR_W-1:0] io_sram_addr0,
  output logic [DATA_W-1:0] io_sram_din0,
  input  logic [DATA_W-1:0] io_sram_dout0
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_pending;

  logic              fire;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    occupancy;

  // A read in flight in the macro counts against FIFO space, so
  // acceptance never outruns the slots available for its data.
  assign occupancy    = {1'b0, count} + {{CNT_W{1'b0}}, rd_pending};
  assign io_req_ready = reset & (occupancy < (CNT_W+1)'(RESP_DEPTH));

  assign fire = io_req_valid & io_req_ready;
  assign push = rd_pending;
  assign pop  = io_resp_valid & io_resp_ready;

  // The macro is driven straight from the accepted request. Address and
  // data pass through even when the macro is deselected.
  assign io_sram_clk0  = clock;
  assign io_sram_csb0  = ~fire;
  assign io_sram_web0  = ~(fire & io_req_write);
  assign io_sram_addr0 = io_req_addr;
  assign io_sram_din0  = io_req_wdata;

  assign io_resp_valid = (count != '0);
  assign io_resp_rdata = fifo_mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pending <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      // dout0 is valid during the cycle after a read fires.
      // The data is captured at the edge that closes that cycle.
      rd_pending <= fire & ~io_req_write;

      if (push) begin
        fifo_mem[wr_ptr] <= io_sram_dout0;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - scoreboard bench for sram_req_ctrl

module tb_sram_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        sram_clk0;
  logic        csb0;
  logic        web0;
  logic [6:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;

  sram_req_ctrl #(.ADDR_W(7), .DATA_W(32), .RESP_DEPTH(4)) dut (
    .clock         (clk),
    .reset         (rst_n),
    .io_req_valid  (req_valid),
    .io_req_ready  (req_ready),
    .io_req_write  (req_write),
    .io_req_addr   (req_addr),
    .io_req_wdata  (req_wdata),
    .io_resp_valid (resp_valid),
    .io_resp_ready (resp_ready),
    .io_resp_rdata (resp_rdata),
    .io_sram_clk0  (sram_clk0),
    .io_sram_csb0  (csb0),
    .io_sram_web0  (web0),
    .io_sram_addr0 (addr0),
    .io_sram_din0  (din0),
    .io_sram_dout0 (dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macro: samples its pins on the rising edge.
  // dout holds the read word until the next read.
  logic [31:0] sram_mem [128];
  always @(posedge sram_clk0) begin
    if (!csb0) begin
      if (!web0) sram_mem[addr0] <= din0;
      else       dout0 <= sram_mem[addr0];
    end
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [128];
  int          checks;
  int          failures;
  int          cyc;
  int          fire_cnt;
  bit          exact_lat;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle. Inputs are driven by the caller just after the rising edge.
  // Outputs are sampled at the falling edge.
  task automatic step();
    logic fire;
    logic exp_valid;
    exp_t e;
    @(negedge clk);
    fire = req_valid && req_ready;
    check("csb0_eq_not_fire", csb0, !fire);
    exp_valid = (exp_q.size() != 0) && (cyc - exp_q[0].cyc >= 2);
    check("resp_valid", resp_valid, exp_valid);
    if (resp_valid && resp_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rdata", resp_rdata, e.data);
      if (exact_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
    end
    if (fire) begin
      fire_cnt++;
      check("addr0", addr0, req_addr);
      check("web0", web0, !req_write);
      if (req_write) begin
        check("din0", din0, req_wdata);
        ref_mem[req_addr] = req_wdata;
      end else begin
        e.data = ref_mem[req_addr];
        e.cyc  = cyc;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int f0;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    fire_cnt   = 0;
    exact_lat  = 1'b0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    dout0      = '0;
    for (int i = 0; i < 128; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_csb0", csb0, 1'b1);
    check("rst_web0", web0, 1'b1);
    check("rst_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 1'b1);

    // 1: write then read the same address; response two cycles after the read
    exact_lat  = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 7'h05;
    req_wdata  = 32'hDEADBEEF;
    step();
    req_write = 1'b0;
    step();
    drain();
    exact_lat = 1'b0;

    // 2: fill every address, then read all back-to-back
    req_valid = 1'b1;
    req_write = 1'b1;
    for (int i = 0; i < 128; i++) begin
      req_addr  = 7'(i);
      req_wdata = 32'(i) * 32'h01010101;
      check("t2_wr_ready", req_ready, 1'b1);
      step();
    end
    req_write = 1'b0;
    for (int i = 0; i < 128; i++) begin
      req_addr = 7'(i);
      check("t2_rd_ready", req_ready, 1'b1);
      step();
    end
    drain();

    // 3: backpressure; only RESP_DEPTH reads may be accepted
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    f0 = fire_cnt;
    for (int i = 0; i < 6; i++) begin
      req_addr = 7'(40 + i);
      step();
    end
    check("t3_accepted", 64'(fire_cnt - f0), 64'd4);
    check("t3_ready_low", req_ready, 1'b0);
    drain();
    check("t3_ready_back", req_ready, 1'b1);

    // 4: one entry held while a push and a pop happen in the same cycle
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 7'd10;
    step();
    req_valid = 1'b0;
    step();
    req_valid = 1'b1;
    req_addr  = 7'd11;
    step();
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 7'(12 + i);
      check("t4_resp_valid_held", resp_valid, 1'b1);
      step();
    end
    drain();

    // 5: reset one cycle after a read fires
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 7'd20;
    step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_ready", req_ready, 1'b0);
    check("t5_rst_resp_valid", resp_valid, 1'b0);
    check("t5_rst_csb0", csb0, 1'b1);
    step();
    step();
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("t5_rel_ready", req_ready, 1'b1);
    check("t5_rel_resp_valid", resp_valid, 1'b0);
    for (int i = 0; i < 4; i++) step();
    req_valid = 1'b1;
    req_addr  = 7'd20;
    step();
    drain();

    // 6: random traffic against the reference memory
    for (int i = 0; i < 10000; i++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_write  = 1'($urandom_range(0, 1));
      req_addr   = 7'($urandom_range(0, 127));
      req_wdata  = $urandom;
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
